// File: rtl/alu_nibble_sequencer_if.sv
// Request/result bundle between the datapath and the nibble sequencer.
// The master drives start/ALUop/operands; the sequencer returns status and result.
interface alu_nibble_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [2:0]   ALUop;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         overflow;

    modport master (
        output start, ALUop, a, b,
        input  busy, done, result, carry, zero, overflow
    );

    modport slave (
        input  start, ALUop, a, b,
        output busy, done, result, carry, zero, overflow
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs wide AND/OR/ADD/SUB through a shared 4-bit slice, one nibble per cycle.
// Optional macro ALU_SEQ_OVERFLOW_EN adds the signed overflow flag.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_nibble_sequencer_if.slave  bus,
    output logic [3:0]             slice_a,
    output logic [3:0]             slice_b,
    output logic [2:0]             slice_ALUop,
    output logic                   slice_carry_in,
    input  logic [3:0]             slice_result,
    input  logic                   slice_carry_out
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [IW-1:0] idx;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [2:0]   op_q;
    logic         c_q;
    logic [W-1:0] res_q;
    logic         carry_q;
    logic         zero_q;
    logic         busy_q;
    logic         done_q;
    logic [W-1:0] res_nxt;
    logic         is_sub;
    logic         is_arith;
    logic         is_known;

    assign is_sub   = (op_q == OP_SUB);
    assign is_arith = (op_q == OP_ADD) || is_sub;
    assign is_known = is_arith || (op_q == OP_AND) || (op_q == OP_OR);

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = res_q;
    assign bus.carry   = carry_q;
    assign bus.zero    = zero_q;
    assign slice_ALUop = op_q;

    always_comb begin
        slice_a        = 4'h0;
        slice_b        = 4'h0;
        slice_carry_in = 1'b0;
        if (state == RUN) begin
            slice_a = a_q[4*idx +: 4];
            slice_b = b_q[4*idx +: 4];
            // SUB seeds the chain with 1 to complete the two's complement
            slice_carry_in = (idx == '0) ? is_sub : (is_arith & c_q);
        end
    end

    always_comb begin
        res_nxt = res_q;
        res_nxt[4*idx +: 4] = slice_result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'b000;
            c_q     <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        op_q    <= bus.ALUop;
                        c_q     <= 1'b0;
                        res_q   <= '0;
                        carry_q <= 1'b0;
                        zero_q  <= 1'b0;
                        idx     <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_nxt;
                    c_q   <= slice_carry_out;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        carry_q <= is_arith & slice_carry_out;
                        zero_q  <= is_known && (res_nxt == '0);
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && idx == LAST) begin
            ovf_q <= is_arith
                  && (a_q[W-1] == (b_q[W-1] ^ is_sub))
                  && (slice_result[3] != a_q[W-1]);
        end
    end

    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer with a behavioural 4-bit slice.
// Expected results are queued at start and popped when done pulses.
module tb_alu_nibble_sequencer;
    localparam int N = 4;
    localparam int W = 4 * N;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_XX  = 3'b011;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] slice_a, slice_b, slice_result;
    logic [2:0] slice_ALUop;
    logic       slice_carry_in, slice_carry_out;
    logic [4:0] s_sum;

    int   n_checks = 0;
    int   n_fail = 0;
    int   done_count = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    alu_nibble_sequencer_if #(.NIBBLES(N)) bus ();

    alu_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus.slave),
        .slice_a         (slice_a),
        .slice_b         (slice_b),
        .slice_ALUop     (slice_ALUop),
        .slice_carry_in  (slice_carry_in),
        .slice_result    (slice_result),
        .slice_carry_out (slice_carry_out)
    );

    // Slice: raw carry-out on every op so the sequencer must gate it itself
    always_comb begin
        s_sum = {1'b0, slice_a}
              + {1'b0, (slice_ALUop == OP_SUB) ? ~slice_b : slice_b}
              + {4'b0, slice_carry_in};
        case (slice_ALUop)
            OP_AND:         slice_result = slice_a & slice_b;
            OP_OR:          slice_result = slice_a | slice_b;
            OP_ADD, OP_SUB: slice_result = s_sum[3:0];
            default:        slice_result = slice_a ^ slice_b;
        endcase
        slice_carry_out = s_sum[4];
    end

    function automatic exp_t model(input logic [2:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        logic [W:0] s;
        e = '0;
        case (op)
            OP_AND: begin e.r = a & b; e.z = (e.r == '0); end
            OP_OR:  begin e.r = a | b; e.z = (e.r == '0); end
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                e.r = s[W-1:0]; e.c = s[W]; e.z = (e.r == '0);
`ifdef ALU_SEQ_OVERFLOW_EN
                e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
`endif
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                e.r = s[W-1:0]; e.c = (a >= b); e.z = (e.r == '0);
`ifdef ALU_SEQ_OVERFLOW_EN
                e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
`endif
            end
            default: e.r = a ^ b;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_count++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done=1 required no pulse");
            end else begin
                mon_e = sb.pop_front();
                n_checks += 4;
                if (bus.result !== mon_e.r) begin
                    n_fail++;
                    $display("FAIL result: got %h required %h", bus.result, mon_e.r);
                end
                if (bus.carry !== mon_e.c) begin
                    n_fail++;
                    $display("FAIL carry: got %b required %b", bus.carry, mon_e.c);
                end
                if (bus.zero !== mon_e.z) begin
                    n_fail++;
                    $display("FAIL zero: got %b required %b", bus.zero, mon_e.z);
                end
                if (bus.overflow !== mon_e.v) begin
                    n_fail++;
                    $display("FAIL overflow: got %b required %b", bus.overflow, mon_e.v);
                end
            end
        end
    end

    task automatic run_op(input logic [2:0] op,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b);
        exp_t e;
        int cyc;
        bit seen;
        logic [W:0] lo;
        logic [W-1:0] bx, mask;
        logic exp_cin;
        e = model(op, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.ALUop = op; bus.a = a; bus.b = b;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < N + 4) begin
            if (bus.done === 1'b1) begin
                seen = 1;
            end else begin
                if (cyc < N) begin
                    bx = (op == OP_SUB) ? ~b : b;
                    mask = (W'(1) << (4 * cyc)) - W'(1);
                    lo = {1'b0, a & mask} + {1'b0, bx & mask}
                       + {{W{1'b0}}, op == OP_SUB};
                    exp_cin = (op == OP_ADD || op == OP_SUB) ? lo[4*cyc] : 1'b0;
                    n_checks += 3;
                    if (slice_a !== a[4*cyc +: 4]) begin
                        n_fail++;
                        $display("FAIL slice_a[%0d]: got %h required %h", cyc, slice_a, a[4*cyc +: 4]);
                    end
                    if (slice_carry_in !== exp_cin) begin
                        n_fail++;
                        $display("FAIL slice_cin[%0d]: got %b required %b", cyc, slice_carry_in, exp_cin);
                    end
                    if (bus.busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL busy_run[%0d]: got %b required 1", cyc, bus.busy);
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        n_checks++;
        if (!seen || cyc != N) begin
            n_fail++;
            $display("FAIL latency: got %0d edges (seen=%0d) required %0d", cyc, seen, N);
        end
        @(posedge clk); #1;
        n_checks += 2;
        if (bus.result !== e.r) begin
            n_fail++;
            $display("FAIL result_hold: got %h required %h", bus.result, e.r);
        end
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_idle: got %b required 0", bus.busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.result, bus.carry, bus.zero, bus.overflow,
             slice_a, slice_b, slice_ALUop, slice_carry_in} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h sa=%h sb=%h op=%b cin=%b required all 0",
                     bus.busy, bus.done, bus.result, slice_a, slice_b, slice_ALUop, slice_carry_in);
        end
        reset = 1'b0;
    endtask

    task automatic test_arith;
        run_op(OP_ADD, 16'h1234, 16'h0FFF);
        run_op(OP_SUB, 16'h0005, 16'h0007);
        run_op(OP_SUB, 16'h1234, 16'h1234);
        run_op(OP_ADD, 16'h7FFF, 16'h0001);
        run_op(OP_ADD, 16'hFFFF, 16'h0001);
        run_op(OP_SUB, 16'h8000, 16'h0001);
    endtask

    task automatic test_logic;
        run_op(OP_AND, 16'hF0F0, 16'h3C3C);
        run_op(OP_OR,  16'hF0F0, 16'h3C3C);
        run_op(OP_AND, 16'hFFFF, 16'h0000);
        run_op(OP_XX,  16'hFFFF, 16'hFFFF);
    endtask

    task automatic test_start_ignored;
        int d0;
        d0 = done_count;
        @(negedge clk);
        bus.start = 1'b1; bus.ALUop = OP_ADD; bus.a = 16'h1111; bus.b = 16'h2222;
        sb.push_back(model(OP_ADD, 16'h1111, 16'h2222));
        @(posedge clk); #1;
        bus.ALUop = OP_SUB; bus.a = 16'hFFFF; bus.b = 16'h0001;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (N + 4) @(posedge clk);
        #1;
        n_checks += 3;
        if (done_count !== d0 + 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d required %0d", done_count - d0, 1);
        end
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_busy: got %b required 0", bus.busy);
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL ignore_pending: got %0d queued required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_run;
        int d0;
        d0 = done_count;
        @(negedge clk);
        bus.start = 1'b1; bus.ALUop = OP_ADD; bus.a = 16'hABCD; bus.b = 16'h1357;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.result, bus.carry, bus.zero, bus.overflow,
             slice_a, slice_b, slice_ALUop, slice_carry_in} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b done=%b result=%h sa=%h op=%b required all 0",
                     bus.busy, bus.done, bus.result, slice_a, slice_ALUop);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (N + 3) @(posedge clk);
        #1;
        n_checks++;
        if (done_count !== d0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d pulses required 0", done_count - d0);
        end
        run_op(OP_SUB, 16'h4000, 16'h0FFF);
    endtask

    task automatic test_reset_with_start;
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1; bus.ALUop = OP_ADD; bus.a = 16'h0001; bus.b = 16'h0001;
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_beats_start: got busy=%b required 0", bus.busy);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [2:0] ops [4];
        ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_ADD; ops[3] = OP_SUB;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[$urandom_range(0, 3)], W'($urandom), W'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.ALUop = 3'b000;
        bus.a = '0;
        bus.b = '0;
        test_reset;
        test_arith;
        test_logic;
        test_start_ignored;
        test_reset_mid_run;
        test_reset_with_start;
        test_back_to_back;
        repeat (2) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Multi-cycle controller that runs wide (4×NIBBLES-bit) AND/OR/ADD/SUB operations through the shared 4-bit ALU slice, one nibble per cycle, LSB first. It sits between the instruction-level datapath and the 4-bit slice (slice adder plus B-inversion mux). It latches full-width operands, drives the slice's A/B/ALUop/carry-in each cycle and chains carry between nibbles. It then assembles the result, carry, zero and optional overflow flags, with a start/busy/done handshake.

## Interface
- NIBBLES, 4, number of 4-bit slices per operation (result width = 4*NIBBLES); legal range 2..8
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  request; sampled only in IDLE
- ALUop  input  3  operation: 000 AND, 001 OR, 010 ADD, 110 SUB; other codes forwarded, flags forced 0
- a  input  4*NIBBLES  operand A, latched on accepted start
- b  input  4*NIBBLES  operand B (uninverted), latched on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result/flags valid
- result  output  4*NIBBLES  assembled result, held until next accepted start
- carry  output  1  final slice carry-out (ADD/SUB only; SUB: 1 = no borrow)
- zero  output  1  result == 0
- overflow  output  1  signed overflow (see Configuration)
- slice_a  output  4  current A nibble to slice
- slice_b  output  4  current B nibble to slice (slice performs inversion)
- slice_ALUop  output  3  latched ALUop to slice
- slice_carry_in  output  1  carry into current slice
- slice_result  input  4  combinational slice result for current nibble
- slice_carry_out  input  1  combinational slice carry-out

## Operation
- States: IDLE, RUN, DONE. Nibble index idx, width ceil(log2 NIBBLES).
- IDLE: start=1 -> latch a, b, ALUop; clear result register and flags; idx=0; -> RUN. start=0 -> stay.
- RUN: slice_a/slice_b = nibble idx of latched operands; slice_ALUop = latched op. Each edge: store slice_result into result[4*idx+3:4*idx], register slice_carry_out into carry chain, idx++. When idx == NIBBLES-1 -> DONE.
- slice_carry_in: idx 0 -> 1 for SUB, 0 otherwise; idx>0 -> registered carry from previous nibble for ADD/SUB, 0 for other ops.
- DONE: done=1 for exactly this cycle; carry = last carry-out (ADD/SUB), else 0; zero computed from full assembled result. -> IDLE unconditionally.
- start while busy (RUN or DONE) ignored, not queued.
- Outside RUN: slice_a, slice_b, slice_carry_in = 0; slice_ALUop holds latched value.
- Arithmetic modulo 2^(4*NIBBLES); no sign extension.

## Timing
- Reset: state IDLE, idx 0, busy 0, done 0, result 0, carry 0, zero 0, overflow 0, all slice_* outputs 0.
- Accept edge E0 (start=1 in IDLE). RUN occupies cycles after E0 through edge E_NIBBLES. done high in the cycle after E_NIBBLES. Start-to-done latency = NIBBLES+1 cycles. Throughput is one operation per NIBBLES+2 cycles.
- Slice is combinational; slice_result/slice_carry_out sampled on the same edge that advances idx.
- reset asserted mid-RUN or in DONE: next edge -> reset values, partial result discarded, no done pulse.
- reset and start in the same cycle: reset wins.
- result/flags stable from the done cycle until the next accepted start edge.

## Configuration
- ALU_SEQ_OVERFLOW_EN defined: on the final nibble, register overflow = (a_msb == (b_msb ^ is_sub)) && (slice_result[3] != a_msb) for ADD/SUB, 0 for other ops. Valid with done.
- Not defined: overflow tied to 0; no overflow logic synthesized.

## Test plan
- NIBBLES=4, ADD 0x1234 + 0x0FFF -> done after 5 cycles, result 0x2233, carry 0, zero 0.
- SUB 0x0005 - 0x0007 -> result 0xFFFE, carry 0, zero 0; SUB 0x1234 - 0x1234 -> result 0x0000, carry 1, zero 1.
- With ALU_SEQ_OVERFLOW_EN, ADD 0x7FFF + 0x0001 -> result 0x8000, overflow 1, carry 0. Without the macro, overflow is 0.
- AND 0xF0F0 & 0x3C3C -> 0x3030; OR -> 0xFCFC. slice_carry_in is 0 every RUN cycle; carry is 0.
- start pulsed again during RUN with different operands -> ignored. The original result completes, with exactly one done pulse.
- reset asserted in the 2nd RUN cycle -> next cycle all outputs at reset values, no done. A new start afterwards completes normally.
